// File: rtl/decode_pipe.sv
// decode_pipe: single-stage instruction decoder with register file, two-word
// immediate instructions, write-through bypass and load-use hazard detection.
// Decoded fields and operands are presented in a registered output stage that
// can be held by a downstream stall or emptied by a flush.
module decode_pipe #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int RA_W    = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_instr_valid,
    output logic               o_ready,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_wb_en,
    input  logic [RA_W-1:0]    i_wb_addr,
    input  logic [DATA_W-1:0]  i_wb_data,
    input  logic               i_ex_mem_read,
    input  logic [RA_W-1:0]    i_ex_rd,
    output logic               o_valid,
    output logic [2:0]         o_opcode,
    output logic [RA_W-1:0]    o_rd,
    output logic [RA_W-1:0]    o_rs,
    output logic [DATA_W-1:0]  o_data1,
    output logic [DATA_W-1:0]  o_data2,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_has_imm,
    output logic               o_hazard
);

    localparam int NREG     = 1 << RA_W;
    localparam int RD_LSB   = INSTR_W - 3 - RA_W;
    localparam int RS_LSB   = RD_LSB - RA_W;
    localparam int FLAG_BIT = RS_LSB - 1;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    // Register file
    logic [DATA_W-1:0] rf_q [NREG];

    // FSM and first-word latch of a two-word instruction
    state_t            state_q, state_d;
    logic [2:0]        lat_op_q, lat_op_d;
    logic [RA_W-1:0]   lat_rd_q, lat_rd_d;
    logic [RA_W-1:0]   lat_rs_q, lat_rs_d;

    // Output register
    logic              valid_q, valid_d;
    logic [2:0]        op_q, op_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [RA_W-1:0]   rs_q, rs_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              has_imm_q, has_imm_d;

    // Incoming word fields
    logic [2:0]        in_op;
    logic [RA_W-1:0]   in_rd;
    logic [RA_W-1:0]   in_rs;
    logic              in_flag;
    logic [DATA_W-1:0] imm_ext;

    // Source fields: incoming word when expecting a first word, latched otherwise
    logic [RA_W-1:0]   src_rd;
    logic [RA_W-1:0]   src_rs;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              hazard;
    logic              ready;
    logic              accept;

    assign in_op   = i_instr[INSTR_W-1 -: 3];
    assign in_rd   = i_instr[RD_LSB +: RA_W];
    assign in_rs   = i_instr[RS_LSB +: RA_W];
    assign in_flag = i_instr[FLAG_BIT];

    // The immediate word is zero-extended or truncated to the operand width.
    generate
        if (DATA_W > INSTR_W) begin : g_imm_zext
            assign imm_ext = {{(DATA_W-INSTR_W){1'b0}}, i_instr};
        end else begin : g_imm_trunc
            assign imm_ext = i_instr[DATA_W-1:0];
        end
    endgenerate

    assign src_rd = (state_q == S_IMM) ? lat_rd_q : in_rd;
    assign src_rs = (state_q == S_IMM) ? lat_rs_q : in_rs;

    // A register being written this cycle is read as its new value.
    assign rd_data1 = (i_wb_en && (i_wb_addr == src_rd)) ? i_wb_data : rf_q[src_rd];
    assign rd_data2 = (i_wb_en && (i_wb_addr == src_rs)) ? i_wb_data : rf_q[src_rs];

    assign hazard = i_instr_valid & i_ex_mem_read &
                    ((i_ex_rd == src_rd) | (i_ex_rd == src_rs));
    assign ready  = ~i_stall & ~hazard & ~i_flush & ~i_reset;
    assign accept = i_instr_valid & ready;

    // Next-state and output-register values; everything holds by default
    always_comb begin
        state_d   = state_q;
        lat_op_d  = lat_op_q;
        lat_rd_d  = lat_rd_q;
        lat_rs_d  = lat_rs_q;
        valid_d   = valid_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        imm_d     = imm_q;
        has_imm_d = has_imm_q;

        if (i_flush) begin
            // Redirect: drop both the output and any half-received instruction.
            valid_d = 1'b0;
            state_d = S_OP;
        end else if (!i_stall) begin
            // Without a completed instruction the output register takes a bubble.
            valid_d = 1'b0;
            if (accept) begin
                if (state_q == S_OP) begin
                    if (in_flag) begin
                        lat_op_d = in_op;
                        lat_rd_d = in_rd;
                        lat_rs_d = in_rs;
                        state_d  = S_IMM;
                    end else begin
                        valid_d   = 1'b1;
                        op_d      = in_op;
                        rd_d      = in_rd;
                        rs_d      = in_rs;
                        data1_d   = rd_data1;
                        data2_d   = rd_data2;
                        imm_d     = '0;
                        has_imm_d = 1'b0;
                    end
                end else begin
                    valid_d   = 1'b1;
                    op_d      = lat_op_q;
                    rd_d      = lat_rd_q;
                    rs_d      = lat_rs_q;
                    data1_d   = rd_data1;
                    data2_d   = rd_data2;
                    imm_d     = imm_ext;
                    has_imm_d = 1'b1;
                    state_d   = S_OP;
                end
            end
        end
    end

    // FSM, first-word latch and output register update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_OP;
            lat_op_q  <= '0;
            lat_rd_q  <= '0;
            lat_rs_q  <= '0;
            valid_q   <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            imm_q     <= '0;
            has_imm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_op_q  <= lat_op_d;
            lat_rd_q  <= lat_rd_d;
            lat_rs_q  <= lat_rs_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            imm_q     <= imm_d;
            has_imm_q <= has_imm_d;
        end
    end

    // Register file write port; reset clears every entry and blocks writes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (i_wb_en) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    assign o_ready   = ready;
    assign o_hazard  = hazard;
    assign o_valid   = valid_q;
    assign o_opcode  = op_q;
    assign o_rd      = rd_q;
    assign o_rs      = rs_q;
    assign o_data1   = data1_q;
    assign o_data2   = data2_q;
    assign o_imm     = imm_q;
    assign o_has_imm = has_imm_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios plus randomized traffic for decode_pipe,
// checked cycle by cycle against a behavioural model of the decoder.
module tb_decode_pipe;

    localparam int DW = 16;
    localparam int IW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instr;
    logic          ivalid;
    logic          ready;
    logic          stall;
    logic          flush;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          exmr;
    logic [AW-1:0] exrd;
    logic          o_valid;
    logic [2:0]    o_opcode;
    logic [AW-1:0] o_rd;
    logic [AW-1:0] o_rs;
    logic [DW-1:0] o_data1;
    logic [DW-1:0] o_data2;
    logic [DW-1:0] o_imm;
    logic          o_has_imm;
    logic          o_hazard;

    always #5 clk = ~clk;

    decode_pipe #(.DATA_W(DW), .INSTR_W(IW), .RA_W(AW)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_instr       (instr),
        .i_instr_valid (ivalid),
        .o_ready       (ready),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_wb_en       (wb_en),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .i_ex_mem_read (exmr),
        .i_ex_rd       (exrd),
        .o_valid       (o_valid),
        .o_opcode      (o_opcode),
        .o_rd          (o_rd),
        .o_rs          (o_rs),
        .o_data1       (o_data1),
        .o_data2       (o_data2),
        .o_imm         (o_imm),
        .o_has_imm     (o_has_imm),
        .o_hazard      (o_hazard)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural model: register contents, pending first word, expected outputs
    logic [DW-1:0] m_rf [8];
    bit            m_pend;
    logic [2:0]    m_lop, m_lrd, m_lrs;
    bit            m_valid;
    logic [2:0]    m_op, m_rd, m_rs;
    logic [DW-1:0] m_d1, m_d2, m_imm;
    bit            m_hasimm;

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic f);
        return {op, rd, rs, f, 6'b0};
    endfunction

    task automatic idle();
        ivalid  = 1'b0;
        instr   = '0;
        stall   = 1'b0;
        flush   = 1'b0;
        rst     = 1'b0;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        exmr    = 1'b0;
        exrd    = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic step(input string tag);
        logic [2:0]    op, rd, rs, srd, srs;
        bit            f, hz, rdy, was_rst;
        logic [DW-1:0] v1, v2;
        op  = instr[15:13];
        rd  = instr[12:10];
        rs  = instr[9:7];
        f   = instr[6];
        srd = m_pend ? m_lrd : rd;
        srs = m_pend ? m_lrs : rs;
        hz  = ivalid && exmr && (exrd == srd || exrd == srs);
        rdy = !stall && !hz && !flush && !rst;
        v1  = (wb_en && wb_addr == srd) ? wb_data : m_rf[srd];
        v2  = (wb_en && wb_addr == srs) ? wb_data : m_rf[srs];
        was_rst = rst;
        #1;
        chk({tag, "_hazard"}, 32'(o_hazard), 32'(hz));
        chk({tag, "_ready"},  32'(ready),    32'(rdy));

        if (rst) begin
            foreach (m_rf[i]) m_rf[i] = '0;
            m_pend = 0; m_valid = 0; m_op = 0; m_rd = 0; m_rs = 0;
            m_d1 = 0; m_d2 = 0; m_imm = 0; m_hasimm = 0;
        end else begin
            if (flush) begin
                m_valid = 0;
                m_pend  = 0;
            end else if (!stall) begin
                if (ivalid && rdy) begin
                    if (!m_pend && f) begin
                        m_valid = 0;
                        m_pend = 1; m_lop = op; m_lrd = rd; m_lrs = rs;
                    end else if (!m_pend) begin
                        m_valid = 1; m_op = op; m_rd = rd; m_rs = rs;
                        m_d1 = v1; m_d2 = v2; m_imm = 0; m_hasimm = 0;
                    end else begin
                        m_valid = 1; m_op = m_lop; m_rd = m_lrd; m_rs = m_lrs;
                        m_d1 = v1; m_d2 = v2; m_imm = instr; m_hasimm = 1;
                        m_pend = 0;
                    end
                end else begin
                    m_valid = 0;
                end
            end
            if (wb_en) m_rf[wb_addr] = wb_data;
        end

        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
        if (m_valid || was_rst) begin
            chk({tag, "_opcode"},  32'(o_opcode),  32'(m_op));
            chk({tag, "_rd"},      32'(o_rd),      32'(m_rd));
            chk({tag, "_rs"},      32'(o_rs),      32'(m_rs));
            chk({tag, "_data1"},   32'(o_data1),   32'(m_d1));
            chk({tag, "_data2"},   32'(o_data2),   32'(m_d2));
            chk({tag, "_imm"},     32'(o_imm),     32'(m_imm));
            chk({tag, "_has_imm"}, 32'(o_has_imm), 32'(m_hasimm));
        end
    endtask

    initial begin
        foreach (m_rf[i]) m_rf[i] = '0;
        m_pend = 0; m_lop = 0; m_lrd = 0; m_lrs = 0;
        m_valid = 0; m_op = 0; m_rd = 0; m_rs = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_hasimm = 0;

        // Reset
        idle(); rst = 1'b1;
        step("reset");
        chk("reset_valid", 32'(o_valid), 32'h0);
        chk("reset_data1", 32'(o_data1), 32'h0);

        // Register write then a plain instruction reading it
        idle(); wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        step("wb_r3");
        idle(); ivalid = 1'b1; instr = mk(3'd2, 3'd3, 3'd0, 1'b0);
        step("plain");
        chk("plain_valid",   32'(o_valid),   32'h1);
        chk("plain_data1",   32'(o_data1),   32'h1234);
        chk("plain_data2",   32'(o_data2),   32'h0);
        chk("plain_has_imm", 32'(o_has_imm), 32'h0);

        // Same-cycle write is visible to the read
        idle(); ivalid = 1'b1; instr = mk(3'd1, 3'd5, 3'd0, 1'b0);
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        step("bypass");
        chk("bypass_data1", 32'(o_data1), 32'hBEEF);

        // Two-word instruction with immediate
        idle(); ivalid = 1'b1; instr = mk(3'd4, 3'd1, 3'd2, 1'b1);
        step("imm_first");
        chk("imm_bubble", 32'(o_valid), 32'h0);
        instr = 16'h00FF;
        step("imm_second");
        chk("imm_valid",   32'(o_valid),   32'h1);
        chk("imm_value",   32'(o_imm),     32'h00FF);
        chk("imm_has_imm", 32'(o_has_imm), 32'h1);
        chk("imm_rd",      32'(o_rd),      32'h1);

        // Load-use hazard, then released
        idle(); ivalid = 1'b1; instr = mk(3'd3, 3'd4, 3'd2, 1'b0);
        exmr = 1'b1; exrd = 3'd2;
        step("hazard_on");
        chk("hazard_bubble", 32'(o_valid), 32'h0);
        exmr = 1'b0;
        step("hazard_off");
        chk("hazard_release_valid", 32'(o_valid), 32'h1);
        chk("hazard_release_rs",    32'(o_rs),    32'h2);

        // Flush during stall discards a latched first word
        idle(); ivalid = 1'b1; instr = mk(3'd5, 3'd6, 3'd1, 1'b1);
        step("flush_first");
        stall = 1'b1; flush = 1'b1; instr = 16'h1111;
        step("flush_stall");
        chk("flush_valid", 32'(o_valid), 32'h0);
        idle(); ivalid = 1'b1; instr = mk(3'd6, 3'd2, 3'd3, 1'b0);
        step("flush_after");
        chk("flush_after_valid",  32'(o_valid),  32'h1);
        chk("flush_after_opcode", 32'(o_opcode), 32'h6);

        // Reset in the middle of a two-word instruction
        idle(); wb_en = 1'b1; wb_addr = 3'd7; wb_data = 16'hAAAA;
        step("wb_r7");
        idle(); ivalid = 1'b1; instr = mk(3'd0, 3'd1, 3'd1, 1'b1);
        step("rst_first");
        rst = 1'b1; wb_en = 1'b1; wb_addr = 3'd7; wb_data = 16'h5555; instr = 16'h5555;
        step("rst_mid");
        chk("rst_mid_valid",   32'(o_valid),   32'h0);
        chk("rst_mid_imm",     32'(o_imm),     32'h0);
        chk("rst_mid_has_imm", 32'(o_has_imm), 32'h0);
        idle(); ivalid = 1'b1; instr = mk(3'd7, 3'd7, 3'd7, 1'b0);
        step("rst_after");
        chk("rst_after_valid",  32'(o_valid),  32'h1);
        chk("rst_after_opcode", 32'(o_opcode), 32'h7);
        chk("rst_after_r7",     32'(o_data1),  32'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            ivalid  = ($urandom_range(0, 3) != 0);
            instr   = 16'($urandom);
            stall   = ($urandom_range(0, 6) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            wb_en   = ($urandom_range(0, 1) == 1);
            wb_addr = 3'($urandom);
            wb_data = 16'($urandom);
            exmr    = ($urandom_range(0, 3) == 0);
            exrd    = 3'($urandom);
            step("rand");
        end

        idle();
        step("drain");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 16, register/operand/immediate width.
REQ-002 Parameter INSTR_W, default 16, instruction word width; SHALL satisfy INSTR_W >= 4+2*RA_W.
REQ-003 Parameter RA_W, default 3, register address width; register count = 2**RA_W.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_instr  input  INSTR_W  instruction or immediate word from fetch.
REQ-007 i_instr_valid  input  1  i_instr carries a word this cycle.
REQ-008 o_ready  output  1  word on i_instr is accepted this cycle when i_instr_valid & o_ready.
REQ-009 i_stall  input  1  downstream stall; hold output register.
REQ-010 i_flush  input  1  discard in-flight instruction (branch/interrupt redirect).
REQ-011 i_wb_en / i_wb_addr / i_wb_data  input  1 / RA_W / DATA_W  register file write port.
REQ-012 i_ex_mem_read / i_ex_rd  input  1 / RA_W  instruction in execute is a load to i_ex_rd.
REQ-013 o_valid  output  1  output register holds a decoded instruction.
REQ-014 o_opcode / o_rd / o_rs  output  3 / RA_W / RA_W  registered decoded fields.
REQ-015 o_data1 / o_data2  output  DATA_W  registered operands read from o_rd / o_rs.
REQ-016 o_imm / o_has_imm  output  DATA_W / 1  registered immediate and its presence flag.
REQ-017 o_hazard  output  1  combinational load-use hazard indication this cycle.

Function
REQ-018 Word format: opcode = i_instr[INSTR_W-1 -: 3], rd = next RA_W bits, rs = next RA_W bits, imm flag = next bit below rs.
REQ-019 Register file: 2**RA_W x DATA_W entries; write on clock edge when i_wb_en; reads combinational.
REQ-020 Write-through bypass: a read whose address equals i_wb_addr while i_wb_en=1 SHALL return i_wb_data in the same cycle.
REQ-021 FSM states S_OP (expect first word) and S_IMM (expect immediate word).
REQ-022 S_OP, accepted word with imm flag=0: load output register (fields, operands, o_has_imm=0, o_imm=0, o_valid=1); stay S_OP.
REQ-023 S_OP, accepted word with imm flag=1: latch opcode/rd/rs internally, load bubble (o_valid=0), go S_IMM.
REQ-024 S_IMM, accepted word: load output register from latched fields, o_imm = word zero-extended or truncated to DATA_W, o_has_imm=1, o_valid=1; go S_OP.
REQ-025 Operands SHALL be read in the cycle the output register loads, using incoming fields in S_OP and latched fields in S_IMM.
REQ-026 Hazard source addresses: incoming rd/rs in S_OP, latched rd/rs in S_IMM.
REQ-027 o_hazard = i_instr_valid & i_ex_mem_read & (i_ex_rd == source rd | i_ex_rd == source rs).
REQ-028 o_ready = ~i_stall & ~o_hazard & ~i_flush & ~i_reset.
REQ-029 Hazard with no stall: word not accepted, output register loads bubble (o_valid=0), FSM state unchanged.
REQ-030 i_stall=1 (no flush): output register and FSM state hold; no word accepted.
REQ-031 No word accepted and no stall: output register loads bubble.
REQ-032 i_flush=1: o_valid<=0, FSM<=S_OP, latched first word discarded; flush overrides stall and hazard; register file writes still occur.
REQ-033 Latency: one cycle from accepting the final word of an instruction to o_valid=1.

Reset
REQ-034 i_reset=1 at a clock edge SHALL clear all register file entries to 0, FSM to S_OP, o_valid, o_opcode, o_rd, o_rs, o_data1, o_data2, o_imm, o_has_imm to 0.
REQ-035 Reset mid-instruction (in S_IMM) SHALL discard the latched first word; o_ready=0 while i_reset=1.
REQ-036 i_reset SHALL take priority over i_flush, i_stall and i_wb_en.

Verification
REQ-037 Write R3=0x1234 via wb, then issue opcode 2, rd=3, rs=0, imm=0 -> next cycle o_valid=1, o_data1=0x1234, o_data2=0, o_has_imm=0.
REQ-038 Issue rd=5 while i_wb_en=1, i_wb_addr=5, i_wb_data=0xBEEF same cycle -> o_data1=0xBEEF (bypass).
REQ-039 Two-word instr rd=1, imm=1, then word 0x00FF -> bubble cycle, then o_valid=1, o_imm=0x00FF, o_has_imm=1.
REQ-040 i_ex_mem_read=1, i_ex_rd=2, incoming rs=2 -> o_hazard=1, o_ready=0, o_valid=0 next cycle; deassert -> instruction decoded next cycle.
REQ-041 First word with imm flag accepted, then i_flush with i_stall=1 -> o_valid=0, next word decoded as a first word (S_OP).
REQ-042 Assert i_reset in S_IMM after writing R7=0xAAAA -> all outputs 0, R7 reads 0, next word treated as first word.
